ram_rd_port: RTL and testbench
==============================

# ram_rd_port

Read-side companion to the team's small falling-edge RAM writers. It holds a 2^ADDR_WIDTH-entry, DATA_WIDTH-bit register memory with a simple write port. It also serves read requests over a valid/ready address channel and returns data over a valid/ready response channel, buffered two deep so that downstream backpressure is never lost. Each response carries the raw word plus a widened copy for 32-bit consumers.

## Interface
- ADDR_WIDTH, 2, memory address width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 8, stored word width
- EXT_WIDTH, 32, width of widened response; must be > DATA_WIDTH
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous reset, active-low
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_addr  in  ADDR_WIDTH  read request address
- rd_addr_vld  in  1  request valid
- rd_addr_rd  out  1  request ready
- rd_data  out  DATA_WIDTH  response word
- rd_data_ext  out  EXT_WIDTH  widened response word (see Configuration)
- rd_data_vld  out  1  response valid
- rd_data_rd  in  1  response ready
- rd_cnt  out  16  count of completed responses, wraps 0xFFFF→0x0000

## Operation
- Memory: written on posedge when wr_en=1. Contents are not cleared by reset.
- Request accept: the handshake occurs when rd_addr_vld & rd_addr_rd. The memory is read combinationally at rd_addr in the accept cycle. The word is pushed into a 2-entry response FIFO.
- Read-during-write to the same address in the same cycle returns the OLD word; the write lands at the edge.
- Response pop: the handshake occurs when rd_data_vld & rd_data_rd. The FIFO head is removed and rd_cnt increments by 1, modulo 2^16.
- The FIFO has occupancy states EMPTY (0), ONE (1) and FULL (2):
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push + pop → ONE, with the new word becoming the head at the next edge.
  - FULL: pop → ONE; push is impossible.
- rd_addr_rd = (occupancy != FULL) and rst_n=1. It depends only on registered state plus rst_n, with no combinational path from rd_data_rd.
- In FULL, a pop in the same cycle does not enable a push. The request waits one cycle.
- rd_data_vld = (occupancy != EMPTY). rd_data and rd_data_ext reflect the FIFO head.
- Response data is held stable while rd_data_vld=1 and rd_data_rd=0.
- Ordering: responses return strictly in request order.
- Reset (rst_n=0 at an edge) has the following effect:
  - Occupancy becomes EMPTY and rd_cnt becomes 0.
  - rd_data_vld=0, and rd_addr_rd is held 0 while rst_n=0.
  - Any buffered responses are discarded, including mid-transfer.
  - Writes presented during reset are ignored.
  - rd_data and rd_data_ext reset to 0.

## Timing
- Read latency: a request accepted at edge N gives rd_data_vld=1 after edge N with the data, i.e. 1 cycle.
- Throughput with rd_data_rd held at 1: one request per cycle indefinitely, and occupancy never exceeds ONE.
- With rd_data_rd=0, at most two requests are accepted; rd_addr_rd drops in the cycle after the second accept.
- After rd_data_rd rises in FULL, rd_addr_rd returns to 1 one cycle later.
- Write-to-read visibility: a write at edge N is visible to a read accepted in cycle N+1 or later.
- First cycle with rst_n=1: rd_addr_rd=1 and rd_data_vld=0.

## Configuration
- RAM_RD_SIGN_EXT_EN defined: rd_data_ext is rd_data sign-extended to EXT_WIDTH, treating stored words as signed.
- RAM_RD_SIGN_EXT_EN undefined: rd_data_ext is rd_data zero-extended, i.e. {(EXT_WIDTH-DATA_WIDTH)'b0, rd_data}.
- rd_data itself is identical in both builds.

## Test plan
- Write 0x11, 0x22, 0x83, 0x7F to addresses 0..3, then request 0,1,2,3 back-to-back with rd_data_rd=1:
  - responses 0x11, 0x22, 0x83, 0x7F on four consecutive cycles, each 1 cycle after its accept;
  - rd_cnt=4 at the end;
  - rd_data_ext for address 2 is 0xFFFFFF83 with RAM_RD_SIGN_EXT_EN, and 0x00000083 without it.
- Backpressure: with rd_data_rd=0, present requests for 0,1,2:
  - only 0 and 1 are accepted, and rd_addr_rd=0 from the cycle after the second accept;
  - rd_data holds 0x11 stable;
  - raising rd_data_rd pops 0x11 then 0x22, and request 2 is accepted one cycle after the first pop, returning 0x83.
- Read-during-write: in the same cycle, wr_en=1 with wr_addr=1 and wr_data=0xAA, and a read request to address 1 is accepted:
  - the response is 0x22;
  - the next read of address 1 returns 0xAA.
- rd_cnt wrap: preload via 65535 pops, then one more pop → rd_cnt=0x0000.
- Reset mid-operation: with FIFO FULL, drive rst_n=0 for one edge:
  - rd_data_vld=0, rd_cnt=0, and rd_addr_rd=0 during reset;
  - after release, rd_addr_rd=1, and a read of address 3 returns 0x7F because memory is retained.

Source files
------------

// File: rtl/ram_rd_port.sv
// Register-file RAM with a valid/ready read port and a two-deep response buffer.
// Build option RAM_RD_SIGN_EXT_EN: sign-extend o_rd_data_ext (default zero-extend).
module ram_rd_port #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int EXT_WIDTH  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   input  logic                  i_rd_addr_vld,
   output logic                  o_rd_addr_rd,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic [EXT_WIDTH-1:0]  o_rd_data_ext,
   output logic                  o_rd_data_vld,
   input  logic                  i_rd_data_rd,
   output logic [15:0]           o_rd_cnt
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   occ_t                  r_occ;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   logic [15:0]           r_cnt;

   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_rdata;

   // Ready comes only from registered occupancy, so a pop in FULL cannot admit a push.
   assign o_rd_addr_rd  = i_rst_n && (r_occ != FULL);
   assign o_rd_data_vld = (r_occ != EMPTY);
   assign w_push        = i_rd_addr_vld && o_rd_addr_rd;
   assign w_pop         = o_rd_data_vld && i_rd_data_rd;
   assign w_rdata       = r_mem[i_rd_addr];

   assign o_rd_data = r_head;
   assign o_rd_cnt  = r_cnt;
`ifdef RAM_RD_SIGN_EXT_EN
   assign o_rd_data_ext = {{(EXT_WIDTH-DATA_WIDTH){r_head[DATA_WIDTH-1]}}, r_head};
`else
   assign o_rd_data_ext = {{(EXT_WIDTH-DATA_WIDTH){1'b0}}, r_head};
`endif

   // Memory is not cleared by reset; the read above sees the pre-edge word.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_wr_en)
         r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_occ  <= EMPTY;
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_pop)
            r_cnt <= r_cnt + 16'd1;
         case (r_occ)
            EMPTY: begin
               if (w_push) begin
                  r_head <= w_rdata;
                  r_occ  <= ONE;
               end
            end
            ONE: begin
               if (w_push && w_pop) begin
                  r_head <= w_rdata;
               end else if (w_push) begin
                  r_tail <= w_rdata;
                  r_occ  <= FULL;
               end else if (w_pop) begin
                  r_occ  <= EMPTY;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_head <= r_tail;
                  r_occ  <= ONE;
               end
            end
            default: r_occ <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_rd_port.sv
// Directed bench for ram_rd_port: readback, backpressure, read-during-write, counter wrap, reset.
module tb_ram_rd_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [1:0]  rd_addr;
   logic        rd_addr_vld;
   logic        rd_addr_rd;
   logic [7:0]  rd_data;
   logic [31:0] rd_data_ext;
   logic        rd_data_vld;
   logic        rd_data_rd;
   logic [15:0] rd_cnt;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef RAM_RD_SIGN_EXT_EN
   localparam logic [31:0] EXT_83 = 32'hFFFF_FF83;
`else
   localparam logic [31:0] EXT_83 = 32'h0000_0083;
`endif

   ram_rd_port dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rd_addr(rd_addr), .i_rd_addr_vld(rd_addr_vld), .o_rd_addr_rd(rd_addr_rd),
      .o_rd_data(rd_data), .o_rd_data_ext(rd_data_ext), .o_rd_data_vld(rd_data_vld),
      .i_rd_data_rd(rd_data_rd), .o_rd_cnt(rd_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; rd_addr_vld = 1'b0; rd_data_rd = 1'b0;
      tick(); tick();
      n_chk++; if (rd_data_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", rd_data_vld); end
      n_chk++; if (rd_addr_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b exp 0", rd_addr_rd); end
      n_chk++; if (rd_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0000", rd_cnt); end
      n_chk++; if (rd_data !== 8'h0) begin n_fail++; $display("FAIL reset_data got %h exp 00", rd_data); end
      n_chk++; if (rd_data_ext !== 32'h0) begin n_fail++; $display("FAIL reset_ext got %h exp 0", rd_data_ext); end
      rst_n = 1'b1;
      #1;
      n_chk++; if (rd_addr_rd !== 1'b1) begin n_fail++; $display("FAIL release_rdy got %b exp 1", rd_addr_rd); end
      n_chk++; if (rd_data_vld !== 1'b0) begin n_fail++; $display("FAIL release_vld got %b exp 0", rd_data_vld); end
   endtask

   task automatic test_readback();
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h83; exp_d[3] = 8'h7F;
      for (int i = 0; i < 4; i++) do_write(2'(i), exp_d[i]);
      rd_data_rd = 1'b1; rd_addr_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         n_chk++; if (rd_addr_rd !== 1'b1) begin n_fail++; $display("FAIL rb_rdy[%0d] got %b exp 1", i, rd_addr_rd); end
         tick();
         n_chk++; if (rd_data_vld !== 1'b1 || rd_data !== exp_d[i]) begin
            n_fail++; $display("FAIL rb_data[%0d] got vld=%b %h exp vld=1 %h", i, rd_data_vld, rd_data, exp_d[i]); end
         if (i == 2) begin
            n_chk++; if (rd_data_ext !== EXT_83) begin n_fail++; $display("FAIL rb_ext got %h exp %h", rd_data_ext, EXT_83); end
         end
      end
      rd_addr_vld = 1'b0;
      tick();
      n_chk++; if (rd_data_vld !== 1'b0) begin n_fail++; $display("FAIL rb_drain_vld got %b exp 0", rd_data_vld); end
      n_chk++; if (rd_cnt !== 16'd4) begin n_fail++; $display("FAIL rb_cnt got %0d exp 4", rd_cnt); end
   endtask

   task automatic test_backpressure();
      rd_data_rd = 1'b0; rd_addr_vld = 1'b1; rd_addr = 2'd0;
      tick();
      rd_addr = 2'd1;
      n_chk++; if (rd_addr_rd !== 1'b1) begin n_fail++; $display("FAIL bp_rdy1 got %b exp 1", rd_addr_rd); end
      tick();
      rd_addr = 2'd2;
      n_chk++; if (rd_addr_rd !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_full got %b exp 0", rd_addr_rd); end
      n_chk++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL bp_hold0 got %h exp 11", rd_data); end
      tick();
      n_chk++; if (rd_addr_rd !== 1'b0 || rd_data_vld !== 1'b1) begin
         n_fail++; $display("FAIL bp_stall got rdy=%b vld=%b exp rdy=0 vld=1", rd_addr_rd, rd_data_vld); end
      n_chk++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL bp_hold1 got %h exp 11", rd_data); end
      rd_data_rd = 1'b1;
      tick();
      n_chk++; if (rd_data !== 8'h22 || rd_addr_rd !== 1'b1) begin
         n_fail++; $display("FAIL bp_pop1 got %h rdy=%b exp 22 rdy=1", rd_data, rd_addr_rd); end
      tick();
      rd_addr_vld = 1'b0;
      n_chk++; if (rd_data !== 8'h83 || rd_data_vld !== 1'b1) begin
         n_fail++; $display("FAIL bp_req2 got %h vld=%b exp 83 vld=1", rd_data, rd_data_vld); end
      tick();
      n_chk++; if (rd_data_vld !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", rd_data_vld); end
      n_chk++; if (rd_cnt !== 16'd7) begin n_fail++; $display("FAIL bp_cnt got %0d exp 7", rd_cnt); end
   endtask

   task automatic test_rdw();
      rd_data_rd = 1'b1;
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hAA;
      rd_addr_vld = 1'b1; rd_addr = 2'd1;
      tick();
      wr_en = 1'b0;
      n_chk++; if (rd_data !== 8'h22) begin n_fail++; $display("FAIL rdw_old got %h exp 22", rd_data); end
      tick();
      rd_addr_vld = 1'b0;
      n_chk++; if (rd_data !== 8'hAA) begin n_fail++; $display("FAIL rdw_new got %h exp aa", rd_data); end
      tick();
      n_chk++; if (rd_cnt !== 16'd9) begin n_fail++; $display("FAIL rdw_cnt got %0d exp 9", rd_cnt); end
   endtask

   task automatic test_cnt_wrap();
      rd_data_rd = 1'b1; rd_addr = 2'd0; rd_addr_vld = 1'b1;
      repeat (65526) tick();
      rd_addr_vld = 1'b0;
      tick();
      n_chk++; if (rd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got %h exp ffff", rd_cnt); end
      rd_addr_vld = 1'b1;
      tick();
      rd_addr_vld = 1'b0;
      tick();
      n_chk++; if (rd_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap got %h exp 0000", rd_cnt); end
   endtask

   task automatic test_reset_mid();
      rd_data_rd = 1'b0; rd_addr_vld = 1'b1; rd_addr = 2'd0;
      tick();
      rd_addr = 2'd1;
      tick();
      rd_addr_vld = 1'b0;
      n_chk++; if (rd_data_vld !== 1'b1 || rd_addr_rd !== 1'b0) begin
         n_fail++; $display("FAIL mid_full got vld=%b rdy=%b exp vld=1 rdy=0", rd_data_vld, rd_addr_rd); end
      rst_n = 1'b0;
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h55;
      tick();
      wr_en = 1'b0;
      n_chk++; if (rd_data_vld !== 1'b0 || rd_cnt !== 16'h0 || rd_addr_rd !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst got vld=%b cnt=%h rdy=%b exp 0 0000 0", rd_data_vld, rd_cnt, rd_addr_rd); end
      rst_n = 1'b1;
      #1;
      n_chk++; if (rd_addr_rd !== 1'b1) begin n_fail++; $display("FAIL mid_release got %b exp 1", rd_addr_rd); end
      rd_data_rd = 1'b1; rd_addr_vld = 1'b1; rd_addr = 2'd3;
      tick();
      rd_addr_vld = 1'b0;
      n_chk++; if (rd_data !== 8'h7F || rd_data_vld !== 1'b1) begin
         n_fail++; $display("FAIL mid_retain got %h vld=%b exp 7f vld=1", rd_data, rd_data_vld); end
      tick();
      n_chk++; if (rd_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_cnt got %0d exp 1", rd_cnt); end
   endtask

   initial begin
      test_reset();
      test_readback();
      test_backpressure();
      test_rdw();
      test_cnt_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
